fetch_stall_unit: RTL and testbench
===================================

FETCH_STALL_UNIT -- requirements
Module: fetch_stall_unit

Interface
REQ-001 The unit SHALL have the parameter RESET_PC, default 16'h0000, which is the PC value loaded on reset.
REQ-002 The unit SHALL have the parameter EXC_VECTOR, default 16'h00F0, which is the PC value loaded on an exception.
REQ-003 The unit SHALL have the parameter NOP_INSTR, default 16'h0000, which is the instruction word placed in IF/ID on a flush.
REQ-004 The unit SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-005 The unit SHALL have port rst, input, 1 bit: reset, synchronous and active-low.
REQ-006 The unit SHALL have port PCHalt, input, 1 bit: 1 means hold the PC this cycle.
REQ-007 The unit SHALL have port BufferHalt, input, 1 bit: 1 means hold the IF/ID buffer this cycle.
REQ-008 The unit SHALL have port ControlHalt, input, 1 bit: 0 means inject a bubble into ID/EX control.
REQ-009 The unit SHALL have port ExceptionFromCU, input, 1 bit: active-low exception request.
REQ-010 The unit SHALL have port BranchTaken, input, 1 bit: 1 means redirect to BranchTarget.
REQ-011 The unit SHALL have port BranchTarget, input, 16 bits: the redirect address.
REQ-012 The unit SHALL have port InstrIn, input, 16 bits: the instruction-memory word at PCOut.
REQ-013 The unit SHALL have port PCOut, output, 16 bits: the current fetch address.
REQ-014 The unit SHALL have port InstrOut, output, 16 bits: the IF/ID instruction.
REQ-015 The unit SHALL have port PCPlus2Out, output, 16 bits: the IF/ID copy of fetch PC + 2.
REQ-016 The unit SHALL have port Bubble, output, 1 bit: 1 means ID/EX control is forced to zero.
REQ-017 The unit SHALL have port Excepted, output, 1 bit: 1 means the unit is in state EXC.
REQ-018 The unit SHALL have port StallCount, output, 8 bits: the saturating count of stall cycles.

Function
REQ-019 The unit SHALL implement the states RUN, STALL and EXC.
REQ-020 Each cycle, events SHALL be resolved in this priority: reset, then exception, then branch, then halt, then normal.
REQ-021 In RUN with no event, PCOut SHALL advance by +2 (16-bit, wrapping from 16'hFFFE to 16'h0000), InstrOut SHALL take InstrIn, and PCPlus2Out SHALL take the old PCOut+2.
REQ-022 When PCHalt=1, PCOut SHALL hold; when BufferHalt=1, InstrOut and PCPlus2Out SHALL hold; each halt SHALL act independently of the other.
REQ-023 Bubble SHALL be registered, equal to ~ControlHalt sampled at the previous edge, giving one cycle of latency.
REQ-024 PCHalt=1 in RUN SHALL move the state to STALL; PCHalt=0 in STALL SHALL return it to RUN the next cycle.
REQ-025 StallCount SHALL increment on every cycle with PCHalt=1 and not in EXC, and SHALL saturate at 8'hFF.
REQ-026 BranchTaken=1 SHALL load PCOut with BranchTarget and load InstrOut with NOP_INSTR, overriding PCHalt and BufferHalt in the same cycle, and SHALL set the state to RUN.
REQ-027 A BranchTarget with bit 0 set SHALL be loaded as given, without alignment correction.
REQ-028 ExceptionFromCU=0 in RUN or STALL SHALL load PCOut with EXC_VECTOR, load InstrOut with NOP_INSTR, set Bubble=1 and enter EXC, overriding any branch in the same cycle.
REQ-029 In EXC, PCOut, InstrOut, PCPlus2Out and StallCount SHALL hold, Bubble SHALL be 1, and Excepted SHALL be 1.
REQ-030 EXC SHALL be left only by reset; all other inputs SHALL be ignored while in EXC.
REQ-031 An instruction SHALL appear on InstrOut one cycle after its address is on PCOut, provided no halt or flush occurs.

Reset
REQ-032 On rst=0 at a clock edge, PCOut SHALL be RESET_PC, InstrOut SHALL be NOP_INSTR, PCPlus2Out SHALL be 0, Bubble SHALL be 1, Excepted SHALL be 0, StallCount SHALL be 0, and the state SHALL be RUN.
REQ-033 Reset SHALL take effect in any state, including mid-stall and EXC, with no partial update of any register.
REQ-034 On the first edge with rst=1, the unit SHALL perform a normal RUN update.

Structure
REQ-035 The state encoding, NOP_INSTR and EXC_VECTOR defaults SHALL reside in a shared package, pipeline_pkg.
REQ-036 The IF/ID register SHALL be one sub-module, if_id_buffer, with hold and flush inputs; the PC, state machine and counter SHALL reside in the top module.

Verification
REQ-037 The bench SHALL drive reset low for 2 cycles, then release with InstrIn=16'h1234, and check PCOut 0, then 2, and InstrOut=16'h1234 one cycle after release.
REQ-038 The bench SHALL hold PCHalt=BufferHalt=1 for 3 cycles at PC 16'h0006, and check that PCOut stays 16'h0006, InstrOut holds, StallCount=3, and the state returns to RUN.
REQ-039 The bench SHALL assert BranchTaken=1 with BranchTarget=16'h0040 while PCHalt=1, and check PCOut=16'h0040 next cycle and InstrOut=NOP_INSTR.
REQ-040 The bench SHALL assert ExceptionFromCU=0 together with BranchTaken=1, and check PCOut=16'h00F0, Excepted=1 and Bubble=1, and that the state is stuck in EXC until rst=0.
REQ-041 The bench SHALL hold PCHalt=1 for 300 cycles and check that StallCount saturates at 8'hFF; it SHALL also run from PC 16'hFFFE and check the next PC is 16'h0000.
REQ-042 The bench SHALL apply ControlHalt=0 for one cycle and check Bubble=1 exactly one cycle later, for one cycle only.

Source files
------------

// File: rtl/pipeline_pkg.sv
// Shared definitions for the fetch stage: FSM encoding, default instruction
// and vector values, and a saturating-increment helper.
package pipeline_pkg;

  typedef enum logic [1:0] {
    ST_RUN   = 2'b00,
    ST_STALL = 2'b01,
    ST_EXC   = 2'b10
  } fsm_state_e;

  localparam logic [15:0] NOP_INSTR_DEF  = 16'h0000;
  localparam logic [15:0] EXC_VECTOR_DEF = 16'h00F0;
  localparam logic [15:0] PC_STEP        = 16'h0002;

  function automatic logic [7:0] sat_inc8(input logic [7:0] value);
    return (value == 8'hFF) ? value : value + 8'h01;
  endfunction

endpackage

// File: rtl/if_id_buffer.sv
// IF/ID pipeline register: holds on request, flushes to a NOP with priority
// over the hold.
module if_id_buffer
  import pipeline_pkg::*;
#(
  parameter logic [15:0] NOP_INSTR = NOP_INSTR_DEF
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        hold_i,
  input  logic        flush_i,
  input  logic [15:0] instr_i,
  input  logic [15:0] pcplus2_i,
  output logic [15:0] instr_o,
  output logic [15:0] pcplus2_o
);

  logic [15:0] instr_q;
  logic [15:0] instr_d;
  logic [15:0] pcplus2_q;
  logic [15:0] pcplus2_d;

  always_comb begin
    instr_d   = instr_q;
    pcplus2_d = pcplus2_q;
    if (flush_i) begin
      instr_d   = NOP_INSTR;
      pcplus2_d = 16'h0000;
    end else if (!hold_i) begin
      instr_d   = instr_i;
      pcplus2_d = pcplus2_i;
    end else begin
      instr_d   = instr_q;
      pcplus2_d = pcplus2_q;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      instr_q   <= NOP_INSTR;
      pcplus2_q <= 16'h0000;
    end else begin
      instr_q   <= instr_d;
      pcplus2_q <= pcplus2_d;
    end
  end

  assign instr_o   = instr_q;
  assign pcplus2_o = pcplus2_q;

endmodule

// File: rtl/fetch_stall_unit.sv
// Fetch-stage PC, RUN/STALL/EXC control FSM and stall counter; resolves
// exception > branch > halt > normal advance every cycle.
module fetch_stall_unit
  import pipeline_pkg::*;
#(
  parameter logic [15:0] RESET_PC   = 16'h0000,
  parameter logic [15:0] EXC_VECTOR = EXC_VECTOR_DEF,
  parameter logic [15:0] NOP_INSTR  = NOP_INSTR_DEF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        PCHalt,
  input  logic        BufferHalt,
  input  logic        ControlHalt,
  input  logic        ExceptionFromCU,
  input  logic        BranchTaken,
  input  logic [15:0] BranchTarget,
  input  logic [15:0] InstrIn,
  output logic [15:0] PCOut,
  output logic [15:0] InstrOut,
  output logic [15:0] PCPlus2Out,
  output logic        Bubble,
  output logic        Excepted,
  output logic [7:0]  StallCount
);

  fsm_state_e  state_q;
  fsm_state_e  state_d;
  logic [15:0] pc_q;
  logic [15:0] pc_d;
  logic        bubble_q;
  logic        bubble_d;
  logic [7:0]  cnt_q;
  logic [7:0]  cnt_d;

  logic        in_exc_s;
  logic        buf_hold_s;
  logic        buf_flush_s;

  assign in_exc_s    = (state_q == ST_EXC);
  // Once excepted the buffer is frozen; otherwise any redirect flushes it.
  assign buf_hold_s  = BufferHalt | in_exc_s;
  assign buf_flush_s = ~in_exc_s & (~ExceptionFromCU | BranchTaken);

  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    bubble_d = ~ControlHalt;
    cnt_d    = cnt_q;
    case (state_q)
      ST_RUN, ST_STALL: begin
        if (PCHalt) begin
          cnt_d = sat_inc8(cnt_q);
        end else begin
          cnt_d = cnt_q;
        end
        if (!ExceptionFromCU) begin
          pc_d     = EXC_VECTOR;
          bubble_d = 1'b1;
          state_d  = ST_EXC;
        end else if (BranchTaken) begin
          pc_d    = BranchTarget;
          state_d = ST_RUN;
        end else if (PCHalt) begin
          pc_d    = pc_q;
          state_d = ST_STALL;
        end else begin
          pc_d    = pc_q + PC_STEP;
          state_d = ST_RUN;
        end
      end
      ST_EXC: begin
        bubble_d = 1'b1;
        state_d  = ST_EXC;
      end
      default: begin
        state_d = ST_RUN;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q  <= ST_RUN;
      pc_q     <= RESET_PC;
      bubble_q <= 1'b1;
      cnt_q    <= 8'h00;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      bubble_q <= bubble_d;
      cnt_q    <= cnt_d;
    end
  end

  if_id_buffer #(
    .NOP_INSTR(NOP_INSTR)
  ) u_if_id (
    .clk_i     (clk),
    .rst_ni    (rst),
    .hold_i    (buf_hold_s),
    .flush_i   (buf_flush_s),
    .instr_i   (InstrIn),
    .pcplus2_i (pc_q + PC_STEP),
    .instr_o   (InstrOut),
    .pcplus2_o (PCPlus2Out)
  );

  assign PCOut      = pc_q;
  assign Bubble     = bubble_q;
  assign Excepted   = in_exc_s;
  assign StallCount = cnt_q;

endmodule

// File: tb/tb_fetch_stall_unit.sv
// Directed-vector bench for fetch_stall_unit: stimulus pushes hand-computed
// post-edge expectations, a monitor pops and compares after each rising edge.
module tb_fetch_stall_unit;
  import pipeline_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        PCHalt = 1'b0;
  logic        BufferHalt = 1'b0;
  logic        ControlHalt = 1'b1;
  logic        ExceptionFromCU = 1'b1;
  logic        BranchTaken = 1'b0;
  logic [15:0] BranchTarget = 16'h0000;
  logic [15:0] InstrIn = 16'h0000;
  logic [15:0] PCOut;
  logic [15:0] InstrOut;
  logic [15:0] PCPlus2Out;
  logic        Bubble;
  logic        Excepted;
  logic [7:0]  StallCount;

  fetch_stall_unit dut (
    .clk(clk), .rst(rst), .PCHalt(PCHalt), .BufferHalt(BufferHalt),
    .ControlHalt(ControlHalt), .ExceptionFromCU(ExceptionFromCU),
    .BranchTaken(BranchTaken), .BranchTarget(BranchTarget), .InstrIn(InstrIn),
    .PCOut(PCOut), .InstrOut(InstrOut), .PCPlus2Out(PCPlus2Out),
    .Bubble(Bubble), .Excepted(Excepted), .StallCount(StallCount)
  );

  always #5 clk = ~clk;

  // -1 in any field means "not checked on this cycle"
  typedef struct {
    string tag;
    int    pc;
    int    instr;
    int    pp2;
    int    bub;
    int    exc;
    int    cnt;
    int    st;
  } exp_t;

  exp_t exp_q[$];
  int   n_total = 0;
  int   n_pass  = 0;

  localparam int RUN   = 0;
  localparam int STALL = 1;
  localparam int EXC   = 2;

  task automatic chk(input string tag, input string fld, input int act, input int exp);
    if (exp >= 0) begin
      n_total++;
      if (act == exp) n_pass++;
      else $display("FAIL %s.%s: got %0h expected %0h", tag, fld, act, exp);
    end
  endtask

  task automatic push(input string tag, input int pc, input int instr, input int pp2,
                      input int bub, input int exc, input int cnt, input int st);
    exp_t e;
    e.tag = tag; e.pc = pc; e.instr = instr; e.pp2 = pp2;
    e.bub = bub; e.exc = exc; e.cnt = cnt; e.st = st;
    exp_q.push_back(e);
    @(negedge clk);
  endtask

  task automatic set_in(input logic r, input logic ph, input logic bh, input logic ch,
                        input logic ex, input logic br, input logic [15:0] tgt,
                        input logic [15:0] ins);
    rst = r; PCHalt = ph; BufferHalt = bh; ControlHalt = ch;
    ExceptionFromCU = ex; BranchTaken = br; BranchTarget = tgt; InstrIn = ins;
  endtask

  // Monitor: outputs are valid every cycle, compare shortly after each edge.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        exp_t e;
        int   st_act;
        e = exp_q.pop_front();
        st_act = (dut.state_q == ST_RUN) ? RUN : (dut.state_q == ST_STALL) ? STALL :
                 (dut.state_q == ST_EXC) ? EXC : 3;
        chk(e.tag, "pc",    int'(PCOut),      e.pc);
        chk(e.tag, "instr", int'(InstrOut),   e.instr);
        chk(e.tag, "pp2",   int'(PCPlus2Out), e.pp2);
        chk(e.tag, "bub",   int'(Bubble),     e.bub);
        chk(e.tag, "exc",   int'(Excepted),   e.exc);
        chk(e.tag, "cnt",   int'(StallCount), e.cnt);
        chk(e.tag, "st",    st_act,           e.st);
      end
    end
  end

  initial begin
    // reset for two cycles
    set_in(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 16'h0000, 16'h0000);
    push("rst1", 16'h0000, 16'h0000, 16'h0000, 1, 0, 0, RUN);
    push("rst2", 16'h0000, 16'h0000, 16'h0000, 1, 0, 0, RUN);
    // release and sequential fetch
    set_in(1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 16'h0000, 16'h1234);
    push("rel", 16'h0002, 16'h1234, 16'h0002, 0, 0, 0, RUN);
    InstrIn = 16'h1111;
    push("seq4", 16'h0004, 16'h1111, 16'h0004, 0, 0, 0, RUN);
    InstrIn = 16'h2222;
    push("seq6", 16'h0006, 16'h2222, 16'h0006, 0, 0, 0, RUN);
    // three-cycle full stall at PC 6
    set_in(1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 16'h0000, 16'h3333);
    for (int i = 1; i <= 3; i++)
      push("stall", 16'h0006, 16'h2222, 16'h0006, 0, 0, i, STALL);
    set_in(1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 16'h0000, 16'h4444);
    push("unstall", 16'h0008, 16'h4444, 16'h0008, 0, 0, 3, RUN);
    // independent halts
    set_in(1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 16'h0000, 16'h5555);
    push("bufhalt", 16'h000A, 16'h4444, 16'h0008, 0, 0, 3, RUN);
    set_in(1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 16'h0000, 16'h6666);
    push("pchalt", 16'h000A, 16'h6666, 16'h000C, 0, 0, 4, STALL);
    // branch overrides both halts
    set_in(1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 16'h0040, 16'h6767);
    push("br_halt", 16'h0040, 16'h0000, -1, -1, 0, 5, RUN);
    // odd target kept as given
    set_in(1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 16'h0041, 16'h6868);
    push("br_odd", 16'h0041, 16'h0000, -1, -1, 0, 5, RUN);
    set_in(1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 16'h0000, 16'h7777);
    push("after_br", 16'h0043, 16'h7777, 16'h0043, 0, 0, 5, RUN);
    // one-cycle bubble request
    set_in(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 16'h0000, 16'h0101);
    push("bub_on", 16'h0045, 16'h0101, 16'h0045, 1, 0, 5, RUN);
    ControlHalt = 1'b1;
    push("bub_off", 16'h0047, 16'h0101, 16'h0047, 0, 0, 5, RUN);
    push("bub_off2", 16'h0049, 16'h0101, 16'h0049, 0, 0, 5, RUN);
    // PC wrap from FFFE
    set_in(1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 16'hFFFE, 16'h0202);
    push("br_fffe", 16'hFFFE, 16'h0000, -1, 0, 0, 5, RUN);
    set_in(1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 16'h0000, 16'h8888);
    push("wrap", 16'h0000, 16'h8888, 16'h0000, 0, 0, 5, RUN);
    // 300-cycle stall, counter saturates
    set_in(1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 16'h0000, 16'h9999);
    for (int i = 1; i <= 300; i++)
      push("sat", 16'h0000, -1, -1, 0, 0, (5 + i > 255) ? 255 : 5 + i, STALL);
    PCHalt = 1'b0;
    push("sat_end", 16'h0002, 16'h9999, 16'h0002, 0, 0, 255, RUN);
    // exception beats a simultaneous branch
    set_in(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 16'h0040, 16'hBBBB);
    push("exc", 16'h00F0, 16'h0000, -1, 1, 1, 255, EXC);
    // EXC ignores everything but reset
    for (int i = 0; i < 4; i++) begin
      set_in(1'b1, 1'b1, 1'b0, 1'b1, i[0], 1'b1, 16'h0080, 16'hAAAA);
      push("exc_hold", 16'h00F0, 16'h0000, -1, 1, 1, 255, EXC);
    end
    set_in(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 16'h0000, 16'hCCCC);
    push("exc_rst", 16'h0000, 16'h0000, 16'h0000, 1, 0, 0, RUN);
    set_in(1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 16'h0000, 16'hABCD);
    push("rerun", 16'h0002, 16'hABCD, 16'h0002, 0, 0, 0, RUN);
    @(negedge clk);
    chk("end", "queue_left", exp_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
